// File: rtl/common_bus_copier.sv
// Word-by-word block copier between two valid/ready bus initiators.
// Optional stall abort: define COMMON_BUS_COPIER_TIMEOUT_EN (limit = TIMEOUT).
module common_bus_copier #(
    parameter int TIMEOUT = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [4:0]  src_address,
    input  logic [4:0]  dst_address,
    input  logic [5:0]  length,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [5:0]  words_done,
    output logic        bus_read_vaild,
    input  logic        bus_read_ready,
    output logic [4:0]  bus_read_address,
    input  logic [31:0] bus_read_data,
    output logic        bus_write_vaild,
    input  logic        bus_write_ready,
    output logic [4:0]  bus_write_address,
    output logic [31:0] bus_write_data
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } state_t;

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("TIMEOUT must be at least 1");
    end

    state_t      state;
    logic [4:0]  src_ptr;
    logic [4:0]  dst_ptr;
    logic [5:0]  len;
    logic [5:0]  count;
    logic [31:0] hold;

`ifdef COMMON_BUS_COPIER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] stall;
    logic          err;
    assign error = err;
`else
    assign error = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            src_ptr <= '0;
            dst_ptr <= '0;
            len     <= '0;
            count   <= '0;
            hold    <= '0;
`ifdef COMMON_BUS_COPIER_TIMEOUT_EN
            stall   <= '0;
            err     <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        src_ptr <= src_address;
                        dst_ptr <= dst_address;
                        len     <= length;
                        count   <= '0;
`ifdef COMMON_BUS_COPIER_TIMEOUT_EN
                        stall   <= '0;
                        err     <= 1'b0;
`endif
                        state   <= (length == 6'd0) ? DONE : READ;
                    end
                end
                READ: begin
                    if (bus_read_ready) begin
                        hold  <= bus_read_data;
                        state <= WRITE;
`ifdef COMMON_BUS_COPIER_TIMEOUT_EN
                        stall <= '0;
                    end else if (stall == TW'(TIMEOUT - 1)) begin
                        stall <= '0;
                        err   <= 1'b1;
                        state <= DONE;
                    end else begin
                        stall <= stall + 1'b1;
`endif
                    end
                end
                WRITE: begin
                    if (bus_write_ready) begin
                        src_ptr <= src_ptr + 5'd1;
                        dst_ptr <= dst_ptr + 5'd1;
                        count   <= count + 6'd1;
                        state   <= (count + 6'd1 == len) ? DONE : READ;
`ifdef COMMON_BUS_COPIER_TIMEOUT_EN
                        stall   <= '0;
                    end else if (stall == TW'(TIMEOUT - 1)) begin
                        stall <= '0;
                        err   <= 1'b1;
                        state <= DONE;
                    end else begin
                        stall <= stall + 1'b1;
`endif
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Every output is a pure decode of registered state.
    assign busy              = (state != IDLE);
    assign done              = (state == DONE);
    assign words_done        = count;
    assign bus_read_vaild    = (state == READ);
    assign bus_read_address  = src_ptr;
    assign bus_write_vaild   = (state == WRITE);
    assign bus_write_address = dst_ptr;
    assign bus_write_data    = hold;

endmodule

// File: tb/tb_common_bus_copier.sv
// Directed self-checking bench for common_bus_copier with a RAM responder.
// Build with COMMON_BUS_COPIER_TIMEOUT_EN to add the stall-abort scenario.
module tb_common_bus_copier;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [4:0]  src_address;
    logic [4:0]  dst_address;
    logic [5:0]  length;
    logic        busy;
    logic        done;
    logic        error;
    logic [5:0]  words_done;
    logic        bus_read_vaild;
    logic        bus_read_ready;
    logic [4:0]  bus_read_address;
    logic [31:0] bus_read_data;
    logic        bus_write_vaild;
    logic        bus_write_ready;
    logic [4:0]  bus_write_address;
    logic [31:0] bus_write_data;

    logic        rd_en;
    logic        wr_en;
    logic        fill_en;
    logic [7:0]  fill_seed;
    logic        log_clr;
    logic [31:0] ram [32];
    logic [4:0]  rlog [$];
    logic [4:0]  wlog [$];

    int total = 0;
    int bad = 0;

    common_bus_copier #(.TIMEOUT(16)) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .src_address(src_address),
        .dst_address(dst_address),
        .length(length),
        .busy(busy),
        .done(done),
        .error(error),
        .words_done(words_done),
        .bus_read_vaild(bus_read_vaild),
        .bus_read_ready(bus_read_ready),
        .bus_read_address(bus_read_address),
        .bus_read_data(bus_read_data),
        .bus_write_vaild(bus_write_vaild),
        .bus_write_ready(bus_write_ready),
        .bus_write_address(bus_write_address),
        .bus_write_data(bus_write_data)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] pat(input logic [7:0] s, input logic [7:0] i);
        return {s, 16'hC0DE, i};
    endfunction

    assign bus_read_ready  = bus_read_vaild & rd_en;
    assign bus_write_ready = bus_write_vaild & wr_en;
    assign bus_read_data   = ram[bus_read_address];

    always @(posedge clock) begin
        if (fill_en) begin
            for (int i = 0; i < 32; i++) ram[i] <= pat(fill_seed, 8'(i));
        end else if (bus_write_vaild && bus_write_ready) begin
            ram[bus_write_address] <= bus_write_data;
            wlog.push_back(bus_write_address);
        end
        if (bus_read_vaild && bus_read_ready) rlog.push_back(bus_read_address);
        if (log_clr) begin
            rlog.delete();
            wlog.delete();
        end
    end

    wire [63:0] outs = 64'({busy, done, error, bus_read_vaild, bus_write_vaild,
                            bus_read_address, bus_write_address,
                            bus_write_data, words_done});

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fill(input logic [7:0] s);
        fill_seed = s;
        fill_en = 1'b1;
        @(posedge clock);
        #1 fill_en = 1'b0;
    endtask

    task automatic clr_logs();
        log_clr = 1'b1;
        @(posedge clock);
        #1 log_clr = 1'b0;
    endtask

    task automatic kick(input logic [4:0] s, input logic [4:0] d, input logic [5:0] n);
        src_address = s;
        dst_address = d;
        length = n;
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
    endtask

    // Returns the cycle number (edge 0 = start accepted) in which done is seen.
    task automatic do_copy(input logic [4:0] s, input logic [4:0] d, input logic [5:0] n,
                           output int cyc, output logic e, output logic [5:0] w);
        cyc = -1;
        e = 1'bx;
        w = 'x;
        kick(s, d, n);
        for (int k = 1; k <= 200; k++) begin
            @(negedge clock);
            if (done) begin
                cyc = k;
                e = error;
                w = words_done;
                break;
            end
        end
    endtask

    initial begin
        int cyc;
        int cnt;
        logic e;
        logic [5:0] w;
        logic [4:0] ra;
        logic [31:0] rd;
        logic found;

        reset = 1'b1;
        start = 1'b0;
        src_address = '0;
        dst_address = '0;
        length = '0;
        rd_en = 1'b1;
        wr_en = 1'b1;
        fill_en = 1'b0;
        fill_seed = '0;
        log_clr = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("reset_outputs", outs, 64'd0);
        reset = 1'b0;

        // Basic 4-word copy 0..3 -> 16..19
        fill(8'h01);
        clr_logs();
        do_copy(5'd0, 5'd16, 6'd4, cyc, e, w);
        check("basic_done_cycle", 64'(cyc), 64'd9);
        check("basic_words_done", 64'(w), 64'd4);
        check("basic_error", 64'(e), 64'd0);
        for (int i = 0; i < 4; i++)
            check($sformatf("basic_ram%0d", 16 + i), 64'(ram[16 + i]), 64'(pat(8'h01, 8'(i))));
        @(negedge clock);
        check("done_one_cycle", 64'({done, busy}), 64'd0);

        // Zero-length copy
        clr_logs();
        do_copy(5'd5, 5'd6, 6'd0, cyc, e, w);
        check("len0_done_cycle", 64'(cyc), 64'd1);
        check("len0_words_done", 64'(w), 64'd0);
        check("len0_no_traffic", 64'(rlog.size() + wlog.size()), 64'd0);

        // Source pointer wraps past 31
        fill(8'h02);
        clr_logs();
        do_copy(5'd30, 5'd2, 6'd4, cyc, e, w);
        check("wrap_done_cycle", 64'(cyc), 64'd9);
        check("wrap_nreads", 64'(rlog.size()), 64'd4);
        check("wrap_nwrites", 64'(wlog.size()), 64'd4);
        if (rlog.size() == 4 && wlog.size() == 4) begin
            logic [4:0] er [4] = '{5'd30, 5'd31, 5'd0, 5'd1};
            for (int i = 0; i < 4; i++) begin
                check($sformatf("wrap_raddr%0d", i), 64'(rlog[i]), 64'(er[i]));
                check($sformatf("wrap_waddr%0d", i), 64'(wlog[i]), 64'(2 + i));
                check($sformatf("wrap_ram%0d", 2 + i), 64'(ram[2 + i]), 64'(pat(8'h02, 8'(er[i]))));
            end
        end

        // Write stalls for 5 cycles; a start during busy is ignored
        fill(8'h03);
        wr_en = 1'b0;
        kick(5'd8, 5'd24, 6'd2);
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (bus_write_vaild) begin
                found = 1'b1;
                break;
            end
        end
        check("stall_write_seen", 64'(found), 64'd1);
        ra = bus_write_address;
        rd = bus_write_data;
        check("stall_addr0", 64'(ra), 64'd24);
        check("stall_data0", 64'(rd), 64'(pat(8'h03, 8'd8)));
        for (int i = 2; i <= 6; i++) begin
            @(negedge clock);
            if (i == 3) begin
                src_address = 5'd0;
                length = 6'd5;
                start = 1'b1;
            end
            if (i == 4) start = 1'b0;
            check($sformatf("stall_hold%0d", i),
                  64'({bus_write_vaild, bus_write_address, bus_write_data}),
                  64'({1'b1, ra, rd}));
        end
        wr_en = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (done) begin
                found = 1'b1;
                w = words_done;
                break;
            end
        end
        check("stall_done_seen", 64'(found), 64'd1);
        check("stall_words_done", 64'(w), 64'd2);
        repeat (3) @(negedge clock);
        check("stall_start_ignored", 64'(busy), 64'd0);
        check("stall_ram24", 64'(ram[24]), 64'(pat(8'h03, 8'd8)));
        check("stall_ram25", 64'(ram[25]), 64'(pat(8'h03, 8'd9)));
        check("stall_ram26", 64'(ram[26]), 64'(pat(8'h03, 8'd26)));

        // Reset in cycle 3 of an 8-word copy
        fill(8'h04);
        kick(5'd0, 5'd8, 6'd8);
        repeat (3) @(negedge clock);
        check("midrst_progress", 64'({busy, words_done}), 64'({1'b1, 6'd1}));
        reset = 1'b1;
        @(negedge clock);
        check("midrst_outputs", outs, 64'd0);
        reset = 1'b0;
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (done || busy) cnt++;
        end
        check("midrst_no_resume", 64'(cnt), 64'd0);
        do_copy(5'd4, 5'd20, 6'd3, cyc, e, w);
        check("after_rst_done_cycle", 64'(cyc), 64'd7);
        check("after_rst_words", 64'(w), 64'd3);
        for (int i = 0; i < 3; i++)
            check($sformatf("after_rst_ram%0d", 20 + i), 64'(ram[20 + i]), 64'(pat(8'h04, 8'(4 + i))));

`ifdef COMMON_BUS_COPIER_TIMEOUT_EN
        // Read ready never comes: abort after 16 stall cycles
        rd_en = 1'b0;
        kick(5'd0, 5'd10, 6'd2);
        cnt = 0;
        found = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clock);
            if (bus_read_vaild) cnt++;
            if (done) begin
                found = 1'b1;
                e = error;
                w = words_done;
                break;
            end
        end
        check("tmo_done_seen", 64'(found), 64'd1);
        check("tmo_vaild_cycles", 64'(cnt), 64'd16);
        check("tmo_error", 64'(e), 64'd1);
        check("tmo_words_done", 64'(w), 64'd0);
        @(negedge clock);
        check("tmo_error_held", 64'({busy, error}), 64'({1'b0, 1'b1}));
        rd_en = 1'b1;
        do_copy(5'd0, 5'd10, 6'd1, cyc, e, w);
        check("tmo_recover_error", 64'(e), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/common_bus_copier.md
COMMON_BUS_COPIER -- requirements
Module: common_bus_copier

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 16: the number of stall cycles before a transfer aborts (used only when the timeout feature is compiled in).
REQ-002 The block SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request a block copy; sampled only in IDLE.
REQ-005 The block SHALL have port src_address, input, 5 bits: first source word address; sampled with start.
REQ-006 The block SHALL have port dst_address, input, 5 bits: first destination word address; sampled with start.
REQ-007 The block SHALL have port length, input, 6 bits: number of words to copy, 0..32; sampled with start.
REQ-008 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse marking the end of a transfer.
REQ-010 The block SHALL have port error, output, 1 bit: valid with done; high means the transfer was aborted.
REQ-011 The block SHALL have port words_done, output, 6 bits: number of words written so far in the current or last transfer.
REQ-012 The block SHALL have ports bus_read_vaild (output, 1 bit), bus_read_ready (input, 1 bit), bus_read_address (output, 5 bits) and bus_read_data (input, 32 bits), forming the read initiator side.
REQ-013 The block SHALL have ports bus_write_vaild (output, 1 bit), bus_write_ready (input, 1 bit), bus_write_address (output, 5 bits) and bus_write_data (output, 32 bits), forming the write initiator side.

Function
REQ-014 The FSM SHALL have four states: IDLE, READ, WRITE and DONE, held in a registered state variable; all bus outputs SHALL be decoded from registered state only.
REQ-015 In IDLE with start=1, the block SHALL latch src/dst/length, clear words_done and error, and go to READ next cycle; if length=0 it SHALL go to DONE instead.
REQ-016 In READ, bus_read_vaild=1 and bus_read_address=current source pointer; bus_write_vaild=0.
REQ-017 In a READ cycle with bus_read_ready=1, the block SHALL capture bus_read_data into a 32-bit hold register and go to WRITE.
REQ-018 In WRITE, bus_write_vaild=1, bus_write_address=current destination pointer and bus_write_data=hold register; bus_read_vaild=0.
REQ-019 In a WRITE cycle with bus_write_ready=1, the block SHALL increment both pointers and words_done; it SHALL go to DONE if words_done+1 equals length, otherwise to READ.
REQ-020 Pointers SHALL wrap modulo 32 (address 31 increments to 0).
REQ-021 Vaild SHALL stay asserted with stable address and data until ready is seen; the block SHALL never deassert vaild before ready except on abort or reset.
REQ-022 Overlapping regions SHALL be copied strictly in ascending order, one word at a time; no overlap correction is applied.
REQ-023 In DONE, done=1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-024 start SHALL be ignored while busy=1.
REQ-025 With zero-latency ready (ready=vaild), a copy of N≥1 words SHALL take 2 cycles per word: start accepted at edge 0, done high in cycle 2N+1; for length=0, done SHALL be high in cycle 1.

Reset
REQ-026 When reset=1 at a rising edge, the FSM SHALL go to IDLE regardless of state, including mid-transfer.
REQ-027 After that edge, busy, done, error, both vaild outputs, both addresses, bus_write_data, words_done, the pointers and the hold register SHALL all be 0.
REQ-028 A transfer interrupted by reset SHALL not resume and SHALL produce no done pulse.

Configuration
REQ-029 With COMMON_BUS_COPIER_TIMEOUT_EN defined, a counter SHALL count consecutive READ/WRITE cycles with vaild=1 and ready=0, clearing on ready; on reaching TIMEOUT it SHALL drop vaild, go to DONE and set error=1 (held until the next accepted start or reset).
REQ-030 With COMMON_BUS_COPIER_TIMEOUT_EN undefined, the block SHALL wait for ready indefinitely, error SHALL be constant 0, and no timeout counter SHALL exist.

Verification
REQ-031 Responder with ready=vaild; src=0, dst=16, length=4, RAM[0..3]=A,B,C,D -> RAM[16..19]=A,B,C,D, done in cycle 9, words_done=4, error=0.
REQ-032 length=0 -> no vaild asserted, done in cycle 1, words_done=0.
REQ-033 src=30, dst=2, length=4 -> reads 30,31,0,1 and writes 2,3,4,5 in that order.
REQ-034 Write responder holds ready low for 5 cycles -> write vaild/address/data stable for all 6 cycles, copy completes correctly; start pulsed while busy is ignored.
REQ-035 Reset asserted in cycle 3 of a length=8 copy -> all outputs 0 next cycle, no done pulse; a new start afterwards completes normally.
REQ-036 With COMMON_BUS_COPIER_TIMEOUT_EN and TIMEOUT=16, read ready stuck at 0 -> vaild drops after 16 stall cycles, done=1 with error=1, words_done=0.
